// File: rtl/tdc_readout_ctrl.sv
// Multi-channel TDC readout: latches channel hits, arbitrates them into a
// record FIFO and streams framed records byte by byte to a UART transmitter.
module tdc_readout_ctrl #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 16,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_acq,
  input  logic                         stop_acq,
  input  logic                         burst_mode,
  input  logic [N_CH-1:0]              ch_valid,
  input  logic [N_CH*DATA_W-1:0]       ch_data,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_byte,
  output logic                         acq_active,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         drop_err,
  output logic [7:0]                   drop_cnt
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam logic [7:0] HDR = 8'hA5;

  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] ts;
    logic [15:0] data;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CH, S_TSH,
    S_TSL, S_DH, S_DL, S_CSUM
  } st_t;

  logic [TS_W-1:0]   ts_cnt;
  logic [N_CH-1:0]   pend;
  logic [DATA_W-1:0] lat_data [N_CH];
  logic [TS_W-1:0]   lat_ts   [N_CH];
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   gnt_ch;
  logic              gnt_vld;
  logic [N_CH-1:0]   gnt_oh;
  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   drop;
  logic [8:0]        drop_sum;

  rec_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              rd_en;
  rec_t              wr_rec;

  st_t               state;
  rec_t              frame;
  logic              elig;
  logic              acc;

  function automatic st_t nxt(input st_t s);
    case (s)
      S_HDR:   return S_CH;
      S_CH:    return S_TSH;
      S_TSH:   return S_TSL;
      S_TSL:   return S_DH;
      S_DH:    return S_DL;
      S_DL:    return S_CSUM;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input st_t s, input rec_t r);
    logic [7:0] cs;
    cs = {4'b0, r.ch} ^ r.ts[15:8] ^ r.ts[7:0]
       ^ r.data[15:8] ^ r.data[7:0];
    case (s)
      S_HDR:   return HDR;
      S_CH:    return {4'b0, r.ch};
      S_TSH:   return r.ts[15:8];
      S_TSL:   return r.ts[7:0];
      S_DH:    return r.data[15:8];
      S_DL:    return r.data[7:0];
      S_CSUM:  return cs;
      default: return 8'h00;
    endcase
  endfunction

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign hit        = acq_active ? ch_valid : '0;

  // Round-robin search: channels at or above rr first, then wrap to 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt_vld && pend[i] && i >= int'(rr)) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt_vld && pend[i]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
    if (fifo_full) begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
    end
  end

  always_comb begin
    gnt_oh   = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < N_CH; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_ch == CH_W'(i));
    end
    drop = hit & pend & ~gnt_oh;
    for (int i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + 9'(drop[i]);
    end
  end

  assign wr_en       = gnt_vld;
  assign wr_rec.ch   = 4'(gnt_ch);
  assign wr_rec.ts   = 16'(lat_ts[gnt_ch]);
  assign wr_rec.data = 16'(lat_data[gnt_ch]);

  assign elig  = !fifo_empty && (!burst_mode || !acq_active);
  assign acc   = tx_valid && tx_ready;
  assign rd_en = elig &&
                 (state == S_IDLE || (state == S_CSUM && acc));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acq_active <= 1'b0;
      ts_cnt     <= '0;
      drop_err   <= 1'b0;
      drop_cnt   <= '0;
    end else if (start_acq) begin
      acq_active <= 1'b1;
      ts_cnt     <= '0;
      drop_err   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (stop_acq)   acq_active <= 1'b0;
      if (acq_active) ts_cnt     <= ts_cnt + TS_W'(1);
      if (|drop) begin
        drop_err <= 1'b1;
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      rr   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (hit[i])         pend[i] <= 1'b1;
        else if (gnt_oh[i]) pend[i] <= 1'b0;
      end
      if (gnt_vld) begin
        rr <= (gnt_ch == CH_W'(N_CH - 1)) ? '0
                                          : gnt_ch + CH_W'(1);
      end
    end
  end

  // A dropped hit leaves the older latched result intact.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (hit[i] && !drop[i]) begin
        lat_data[i] <= ch_data[i*DATA_W +: DATA_W];
        lat_ts[i]   <= ts_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
      frame    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_en) begin
            frame    <= mem[rp];
            state    <= S_HDR;
            tx_valid <= 1'b1;
            tx_byte  <= HDR;
          end
        end
        S_CSUM: begin
          if (acc) begin
            if (rd_en) begin
              frame   <= mem[rp];
              state   <= S_HDR;
              tx_byte <= HDR;
            end else begin
              state    <= S_IDLE;
              tx_valid <= 1'b0;
              tx_byte  <= '0;
            end
          end
        end
        default: begin
          if (acc) begin
            state   <= nxt(state);
            tx_byte <= byte_of(nxt(state), frame);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Bench for tdc_readout_ctrl: directed scenarios plus randomized hit bursts
// checked against a frame-level reference model.
module tb_tdc_readout_ctrl;

  localparam int N_CH   = 4;
  localparam int DATA_W = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start_acq = 1'b0;
  logic                   stop_acq = 1'b0;
  logic                   burst_mode = 1'b0;
  logic [N_CH-1:0]        ch_valid = '0;
  logic [N_CH*DATA_W-1:0] ch_data = '0;
  logic                   tx_ready = 1'b0;
  logic                   tx_valid;
  logic [7:0]             tx_byte;
  logic                   acq_active;
  logic [4:0]             fifo_level;
  logic                   drop_err;
  logic [7:0]             drop_cnt;

  tdc_readout_ctrl #(
    .N_CH(N_CH), .DATA_W(DATA_W), .TS_W(16), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .start_acq(start_acq), .stop_acq(stop_acq),
    .burst_mode(burst_mode),
    .ch_valid(ch_valid), .ch_data(ch_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_byte(tx_byte), .acq_active(acq_active),
    .fifo_level(fifo_level), .drop_err(drop_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int ts;
    int data;
  } rec_t;

  int         checks = 0;
  int         errors = 0;
  rec_t       exp_q[$];
  logic [7:0] rx_q[$];
  int         rdy_mode = 1;
  bit         m_acq = 1'b0;
  int         m_ts = 0;
  int         m_ptr = 0;
  int         burst_data [N_CH];
  int         stall_bad = 0;
  int         stall_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;

  // Collect accepted bytes; flag any change of a stalled byte.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if (!(tx_valid === 1'b1 && tx_byte === prev_byte))
          stall_bad <= stall_bad + 1;
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
      prev_stall <= tx_valid && !tx_ready;
      prev_byte  <= tx_byte;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (start_acq) begin
      m_acq = 1'b1;
      m_ts  = 0;
    end else begin
      if (m_acq) m_ts = (m_ts + 1) & 16'hFFFF;
      if (stop_acq) m_acq = 1'b0;
    end
    #1;
    start_acq = 1'b0;
    stop_acq  = 1'b0;
    ch_valid  = '0;
    case (rdy_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = ~tx_ready;
    endcase
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic hit(input int c, input int d);
    ch_valid[c] = 1'b1;
    ch_data[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  // Expected record order for a set of simultaneous hits: cyclic from ptr.
  task automatic push_burst(input logic [N_CH-1:0] mask, input int ts);
    int last;
    last = -1;
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = (m_ptr + k) % N_CH;
      if (mask[c]) begin
        exp_q.push_back('{c, ts, burst_data[c]});
        last = c;
      end
    end
    if (last >= 0) m_ptr = (last + 1) % N_CH;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(2);
    m_acq = 1'b0;
    m_ts  = 0;
    m_ptr = 0;
    rx_q.delete();
    exp_q.delete();
    rst = 1'b1;
    cyc();
  endtask

  task automatic wait_drain(input int n, input string tag);
    int k;
    k = 0;
    while (k < 3000 &&
           !(rx_q.size() >= n && fifo_level == 0 && !tx_valid)) begin
      cyc();
      k++;
    end
    chk(tag, 32'(k < 3000), 32'd1);
  endtask

  task automatic check_frames(input string tag);
    logic [7:0] eb[$];
    logic [7:0] b [5];
    logic [7:0] x;
    foreach (exp_q[i]) begin
      b[0] = 8'(exp_q[i].ch);
      b[1] = 8'(exp_q[i].ts >> 8);
      b[2] = 8'(exp_q[i].ts);
      b[3] = 8'(exp_q[i].data >> 8);
      b[4] = 8'(exp_q[i].data);
      x = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
      eb.push_back(8'hA5);
      for (int k = 0; k < 5; k++) eb.push_back(b[k]);
      eb.push_back(x);
    end
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(eb.size()));
    foreach (eb[i]) begin
      chk($sformatf("%s_byte%0d", tag, i),
          (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hxxxxxxxx,
          {24'h0, eb[i]});
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin
    int t;
    int d;
    int nb;
    int k;
    logic [N_CH-1:0] mask;

    // Reset values
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_acq", 32'(acq_active), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // Single hit on ch2, ts 5, latency and frame content
    burst_mode = 1'b0;
    rdy_mode = 1;
    tx_ready = 1'b1;
    start_acq = 1'b1;
    cyc();
    chk("t1_acq", 32'(acq_active), 1);
    cycles(5);
    hit(2, 'h0123);
    cyc();
    chk("t1_e0_level", 32'(fifo_level), 0);
    chk("t1_e0_valid", 32'(tx_valid), 0);
    cyc();
    chk("t1_e1_level", 32'(fifo_level), 1);
    chk("t1_e1_valid", 32'(tx_valid), 0);
    cyc();
    chk("t1_e2_valid", 32'(tx_valid), 1);
    chk("t1_e2_byte", 32'(tx_byte), 32'hA5);
    chk("t1_e2_level", 32'(fifo_level), 0);
    exp_q.push_back('{2, 5, 'h0123});
    wait_drain(7, "t1_drain");
    check_frames("t1");

    // Four simultaneous hits, burst mode holds output
    do_reset();
    burst_mode = 1'b1;
    rdy_mode = 0;
    tx_ready = 1'b0;
    start_acq = 1'b1;
    cyc();
    cycles(3);
    t = m_ts;
    for (int c = 0; c < N_CH; c++) begin
      d = int'($urandom_range(0, 65535));
      hit(c, d);
      exp_q.push_back('{c, t, d});
    end
    cyc();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("t2_level%0d", i), 32'(fifo_level), 32'(i));
    end
    chk("t2_drop_cnt", 32'(drop_cnt), 0);
    cycles(3);
    chk("t2_hold_valid", 32'(tx_valid), 0);
    chk("t2_hold_rx", 32'(rx_q.size()), 0);
    stop_acq = 1'b1;
    rdy_mode = 1;
    cyc();
    chk("t2_acq_off", 32'(acq_active), 0);
    wait_drain(28, "t2_drain");
    check_frames("t2");

    // FIFO overflow on ch0, then toggled readout
    do_reset();
    burst_mode = 1'b1;
    rdy_mode = 0;
    start_acq = 1'b1;
    cyc();
    for (int j = 0; j < 18; j++) begin
      d = int'($urandom_range(0, 65535));
      if (j < 17) exp_q.push_back('{0, m_ts, d});
      hit(0, d);
      cyc();
      cyc();
    end
    chk("t3_level", 32'(fifo_level), 16);
    chk("t3_drop_cnt", 32'(drop_cnt), 1);
    chk("t3_drop_err", 32'(drop_err), 1);
    stop_acq = 1'b1;
    rdy_mode = 3;
    cyc();
    wait_drain(17 * 7, "t3_drain");
    check_frames("t3");
    chk("t3_stalls_seen", 32'(stall_seen > 0), 1);

    // Hits while idle are ignored; start clears drop state
    rdy_mode = 1;
    hit(1, 'h0055);
    cyc();
    cycles(4);
    chk("t3_idle_level", 32'(fifo_level), 0);
    chk("t3_idle_valid", 32'(tx_valid), 0);
    chk("t3_sticky_cnt", 32'(drop_cnt), 1);
    start_acq = 1'b1;
    cyc();
    chk("t3_clr_cnt", 32'(drop_cnt), 0);
    chk("t3_clr_err", 32'(drop_err), 0);
    stop_acq = 1'b1;
    cyc();

    // Randomized bursts with random ready
    do_reset();
    for (int r = 0; r < 6; r++) begin
      burst_mode = 1'($urandom_range(0, 1));
      rdy_mode = 2;
      start_acq = 1'b1;
      cyc();
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
        cycles(int'($urandom_range(0, 3)));
        mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
        for (int c = 0; c < N_CH; c++) begin
          if (mask[c]) begin
            burst_data[c] = int'($urandom_range(0, 65535));
            hit(c, burst_data[c]);
          end
        end
        push_burst(mask, m_ts);
        cyc();
        cycles(N_CH + 1);
      end
      if (burst_mode) chk("rnd_burst_hold", 32'(tx_valid), 0);
      stop_acq = 1'b1;
      cyc();
      wait_drain(exp_q.size() * 7, "rnd_drain");
      check_frames($sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of a frame
    do_reset();
    burst_mode = 1'b0;
    rdy_mode = 1;
    tx_ready = 1'b1;
    start_acq = 1'b1;
    cyc();
    cycles(2);
    t = m_ts;
    hit(1, 'hBEEF);
    cyc();
    hit(2, 'h1234);
    hit(3, 'h4321);
    cyc();
    k = 0;
    while (rx_q.size() < 3 && k < 50) begin
      cyc();
      k++;
    end
    chk("t5_reach_tsl", 32'(k < 50), 1);
    rdy_mode = 0;
    tx_ready = 1'b0;
    #2;
    chk("t5_pre_valid", 32'(tx_valid), 1);
    chk("t5_pre_tsl", 32'(tx_byte), 32'(t & 8'hFF));
    chk("t5_pre_level", 32'(fifo_level), 2);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(tx_valid), 0);
    chk("t5_rst_level", 32'(fifo_level), 0);
    chk("t5_rst_drop", 32'(drop_cnt), 0);
    chk("t5_rst_acq", 32'(acq_active), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycles(3);
    chk("stall_stability", 32'(stall_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
